dff_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register among NREQ requesters. Each requester raises req and presents write data. The arbiter grants one requester at a time, commits its data into the shared register, and reports the last writer. It sits in front of the positive-edge D flip-flop storage and is the only block allowed to drive that storage's load path.

---
 rtl/dff_arb_pkg.sv | 9 +
 rtl/dff_reg_arbiter_if.sv | 16 +
 rtl/dff_reg_arbiter_rr_pick.sv | 21 ++
 rtl/dff_reg_arbiter.sv | 74 +++++++
 tb/tb_dff_reg_arbiter.sv | 135 +++++++++++++
 5 files changed

// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared types, default sizes and helpers for the register arbiter
package dff_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction
endpackage

// File: rtl/dff_reg_arbiter_if.sv
// dff_reg_arbiter_if: requester-side bus of the shared register arbiter
interface dff_reg_arbiter_if #(
  parameter int NREQ = dff_arb_pkg::NREQ_DEF,
  parameter int WIDTH = dff_arb_pkg::WIDTH_DEF
);
  localparam int IDXW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic done;
  logic [WIDTH-1:0] q;
  logic [IDXW-1:0] owner;
  logic busy;
  modport master(output req, wdata, input gnt, done, q, owner, busy);
  modport slave(input req, wdata, output gnt, done, q, owner, busy);
endinterface

// File: rtl/dff_reg_arbiter_rr_pick.sv
// rr_pick: first set request scanning upward from ptr, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic valid
);
  // scan from the farthest offset down so the nearest set bit after ptr wins
  always_comb begin
    idx = '0;
    valid = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) idx = IDXW'(j);
    end
  end
endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin arbiter committing one requester's data into a shared register
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  dff_reg_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] widx_q, widx_d, ptr_q, ptr_d, owner_q, owner_d, win;
  logic [WIDTH-1:0] q_q, q_d;
  logic done_q, done_d, any;
  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req(bus.req),
    .ptr(ptr_q),
    .idx(win),
    .valid(any)
  );
  // grant in IDLE, then commit or drop in GRANT; every grant lasts one cycle
  always_comb begin
    state_d = state_q;
    gnt_d = '0;
    widx_d = widx_q;
    ptr_d = ptr_q;
    q_d = q_q;
    owner_d = owner_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (any) begin
        gnt_d = NREQ'(onehot(3'(win)));
        widx_d = win;
        state_d = GRANT;
      end
    end else begin
      state_d = IDLE;
      if (bus.req[widx_q]) begin
        q_d = bus.wdata[widx_q*WIDTH +: WIDTH];
        owner_d = widx_q;
        done_d = 1'b1;
        ptr_d = (widx_q == IDXW'(NREQ - 1)) ? '0 : widx_q + 1'b1;
      end
    end
  end
  // state and shared register, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      widx_q <= '0;
      ptr_q <= '0;
      q_q <= '0;
      owner_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      widx_q <= widx_d;
      ptr_q <= ptr_d;
      q_q <= q_d;
      owner_q <= owner_d;
      done_q <= done_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.q = q_q;
  assign bus.owner = owner_q;
  assign bus.busy = (state_q == GRANT);
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed checks of grant order, commit timing, withdrawal and reset
module tb_dff_reg_arbiter;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  dff_reg_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();
  dff_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_out(input string tag, input logic [7:0] q, input logic [1:0] owner);
    check({tag, "_gnt"}, 32'(bus.gnt), 0);
    check({tag, "_q"}, 32'(bus.q), 32'(q));
    check({tag, "_owner"}, 32'(bus.owner), 32'(owner));
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask
  task automatic grant(input string tag, input logic [3:0] g);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, "_busy"}, 32'(bus.busy), 1);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask
  task automatic commit(input string tag, input logic [7:0] q, input logic [1:0] owner);
    check({tag, "_q"}, 32'(bus.q), 32'(q));
    check({tag, "_owner"}, 32'(bus.owner), 32'(owner));
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_gnt"}, 32'(bus.gnt), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.wdata = '0;
    #1;
    idle_out("reset", 8'h00, 2'd0);
    check("reset_busy", 32'(bus.busy), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.req = 4'b0001;
    bus.wdata[7:0] = 8'hA5;
    tick();
    grant("rstmid_pre", 4'b0001);
    #2 rst = 1'b1;
    #1;
    idle_out("rstmid_async", 8'h00, 2'd0);
    check("rstmid_busy", 32'(bus.busy), 0);
    tick();
    check("rstmid_nodone", 32'(bus.done), 0);
    check("rstmid_q", 32'(bus.q), 0);
    rst = 1'b0;
    bus.req = '0;
    tick();
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      grant($sformatf("rr%0d", k), 4'(1 << (k % 4)));
      tick();
      commit($sformatf("rr%0d", k), 8'(8'h10 + k % 4), 2'(k % 4));
    end
    bus.req = '0;
    tick();
    idle_out("rr_end", 8'h10, 2'd0);
    bus.wdata[23:16] = 8'h3C;
    bus.req = 4'b0100;
    tick();
    grant("single", 4'b0100);
    tick();
    commit("single", 8'h3C, 2'd2);
    bus.req = '0;
    tick();
    idle_out("single_after", 8'h3C, 2'd2);
    bus.wdata[15:8] = 8'h21;
    bus.req = 4'b0010;
    tick();
    grant("wd", 4'b0010);
    bus.req = '0;
    tick();
    idle_out("wd_drop", 8'h3C, 2'd2);
    check("wd_busy", 32'(bus.busy), 0);
    bus.req = 4'b0010;
    tick();
    grant("wd_again", 4'b0010);
    tick();
    commit("wd_again", 8'h21, 2'd1);
    bus.req = 4'b0100;
    tick();
    grant("wrap_pre", 4'b0100);
    tick();
    commit("wrap_pre", 8'h3C, 2'd2);
    bus.wdata[7:0] = 8'h50;
    bus.wdata[23:16] = 8'h52;
    bus.req = 4'b0101;
    tick();
    grant("wrap0", 4'b0001);
    tick();
    commit("wrap0", 8'h50, 2'd0);
    tick();
    grant("wrap2", 4'b0100);
    tick();
    commit("wrap2", 8'h52, 2'd2);
    bus.req = '0;
    bus.wdata[31:24] = 8'h33;
    bus.wdata[15:8] = 8'h61;
    bus.req = 4'b1000;
    tick();
    grant("late3", 4'b1000);
    bus.req = 4'b1010;
    tick();
    commit("late3", 8'h33, 2'd3);
    bus.req = 4'b0010;
    tick();
    grant("late1", 4'b0010);
    tick();
    commit("late1", 8'h61, 2'd1);
    bus.req = '0;
    tick();
    idle_out("hold", 8'h61, 2'd1);
    tick();
    tick();
    idle_out("hold2", 8'h61, 2'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
